// File: rtl/adc_lane_align.sv
// adc_lane_align: per-lane IDELAY sweep, window centring and bitslip
// word alignment for one deserialized ADC lane, with loss monitoring.

module adc_lane_align #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] PATTERN   = 8'hF0,
    parameter int               TAP_BITS  = 5,
    parameter int               SETTLE    = 16,
    parameter int               CHECK_LEN = 64
) (
    input  logic                     clk,
    input  logic                     rst_pro,
    input  logic                     start,
    input  logic [WIDTH-1:0]         data_in,
    output logic [TAP_BITS-1:0]      dly_tap,
    output logic                     dly_ld,
    output logic                     bitslip,
    output logic                     busy,
    output logic                     done,
    output logic                     locked,
    output logic                     err,
    output logic                     lost,
    output logic [TAP_BITS:0]        win_len,
    output logic [$clog2(WIDTH)-1:0] slip_cnt
);

    localparam int SW      = $clog2(WIDTH);
    localparam int CNT_MAX = (SETTLE > CHECK_LEN) ? SETTLE : CHECK_LEN;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_TAP_LD    = 4'd1;
    localparam logic [3:0] S_TAP_WAIT  = 4'd2;
    localparam logic [3:0] S_TAP_CHK   = 4'd3;
    localparam logic [3:0] S_TAP_NEXT  = 4'd4;
    localparam logic [3:0] S_CENTER_LD = 4'd5;
    localparam logic [3:0] S_SLIP_WAIT = 4'd6;
    localparam logic [3:0] S_SLIP_CHK  = 4'd7;
    localparam logic [3:0] S_SLIP      = 4'd8;
    localparam logic [3:0] S_LOCKED    = 4'd9;
    localparam logic [3:0] S_FAIL      = 4'd10;

    logic [3:0]          state_q, state_d;
    logic [TAP_BITS-1:0] tap_q, tap_d;
    logic                ld_q, ld_d;
    logic                bs_q, bs_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                locked_q, locked_d;
    logic                err_q, err_d;
    logic                lost_q, lost_d;
    logic [TAP_BITS:0]   win_q, win_d;
    logic [SW-1:0]       slip_q, slip_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]    first_q, first_d;
    logic                rot_ok_q, rot_ok_d;
    logic                pass_q, pass_d;
    logic [TAP_BITS-1:0] run_start_q, run_start_d;
    logic [TAP_BITS:0]   run_len_q, run_len_d;
    logic [TAP_BITS-1:0] best_start_q, best_start_d;
    logic [TAP_BITS:0]   best_len_q, best_len_d;
    logic                armed_q;

    logic                go;
    logic                last_tap;
    logic                close_run;
    logic                take;
    logic [TAP_BITS-1:0] cand_start;
    logic [TAP_BITS:0]   cand_len;
    logic [TAP_BITS-1:0] fin_start;
    logic [TAP_BITS:0]   fin_len;

    function automatic logic is_rot(input logic [WIDTH-1:0] w);
        logic [WIDTH-1:0] r;
        logic             hit;
        r   = PATTERN;
        hit = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w == r) hit = 1'b1;
            r = {r[WIDTH-2:0], r[WIDTH-1]};
        end
        return hit;
    endfunction

    // armed_q masks a start seen on the first edge after reset release
    assign go = start && armed_q;

    always_comb begin
        last_tap   = &tap_q;
        cand_len   = run_len_q + {{TAP_BITS{1'b0}}, pass_q};
        cand_start = (run_len_q == '0) ? tap_q : run_start_q;
        close_run  = !pass_q || last_tap;
        take       = close_run && (cand_len > best_len_q);
        fin_len    = take ? cand_len : best_len_q;
        fin_start  = take ? cand_start : best_start_q;
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        ld_d         = 1'b0;
        bs_d         = 1'b0;
        busy_d       = busy_q;
        done_d       = done_q;
        locked_d     = locked_q;
        err_d        = err_q;
        lost_d       = lost_q;
        win_d        = win_q;
        slip_d       = slip_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        rot_ok_d     = rot_ok_q;
        pass_d       = pass_q;
        run_start_d  = run_start_q;
        run_len_d    = run_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;

        unique case (state_q)
            S_TAP_LD, S_CENTER_LD: begin
                ld_d    = 1'b1;
                cnt_d   = '0;
                state_d = (state_q == S_TAP_LD) ? S_TAP_WAIT : S_SLIP_WAIT;
            end
            S_TAP_WAIT: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_TAP_CHK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TAP_CHK: begin
                if (cnt_q == '0) begin
                    first_d  = data_in;
                    rot_ok_d = is_rot(data_in);
                    cnt_d    = cnt_q + 1'b1;
                end else if (data_in != first_q) begin
                    pass_d  = 1'b0;
                    state_d = S_TAP_NEXT;
                end else if (cnt_q == CW'(CHECK_LEN - 1)) begin
                    pass_d  = rot_ok_q;
                    state_d = S_TAP_NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_TAP_NEXT: begin
                if (close_run) begin
                    run_len_d    = '0;
                    best_len_d   = fin_len;
                    best_start_d = fin_start;
                end else begin
                    run_len_d   = cand_len;
                    run_start_d = cand_start;
                end
                if (!last_tap) begin
                    tap_d   = tap_q + 1'b1;
                    state_d = S_TAP_LD;
                end else if (fin_len == '0) begin
                    state_d  = S_FAIL;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                end else begin
                    tap_d   = fin_start + TAP_BITS'((fin_len - 1'b1) >> 1);
                    win_d   = fin_len;
                    state_d = S_CENTER_LD;
                end
            end
            S_SLIP_WAIT: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SLIP_CHK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SLIP_CHK: begin
                if (data_in == PATTERN) begin
                    state_d  = S_LOCKED;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b1;
                end else if (slip_q == SW'(WIDTH - 1)) begin
                    state_d  = S_FAIL;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    locked_d = 1'b0;
                end else begin
                    state_d = S_SLIP;
                end
            end
            S_SLIP: begin
                bs_d    = 1'b1;
                slip_d  = slip_q + 1'b1;
                cnt_d   = '0;
                state_d = S_SLIP_WAIT;
            end
            S_LOCKED: begin
                if (data_in != PATTERN) begin
                    locked_d = 1'b0;
                    lost_d   = 1'b1;
                end
            end
            default: ;
        endcase

        if (go && (state_q == S_IDLE || state_q == S_LOCKED ||
                   state_q == S_FAIL)) begin
            state_d    = S_TAP_LD;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            err_d      = 1'b0;
            lost_d     = 1'b0;
            locked_d   = 1'b0;
            win_d      = '0;
            slip_d     = '0;
            tap_d      = '0;
            run_len_d  = '0;
            best_len_d = '0;
            best_start_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_pro) begin
        if (rst_pro) begin
            state_q      <= S_IDLE;
            tap_q        <= '0;
            ld_q         <= 1'b0;
            bs_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            lost_q       <= 1'b0;
            win_q        <= '0;
            slip_q       <= '0;
            cnt_q        <= '0;
            first_q      <= '0;
            rot_ok_q     <= 1'b0;
            pass_q       <= 1'b0;
            run_start_q  <= '0;
            run_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            tap_q        <= tap_d;
            ld_q         <= ld_d;
            bs_q         <= bs_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            lost_q       <= lost_d;
            win_q        <= win_d;
            slip_q       <= slip_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            rot_ok_q     <= rot_ok_d;
            pass_q       <= pass_d;
            run_start_q  <= run_start_d;
            run_len_q    <= run_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
            armed_q      <= 1'b1;
        end
    end

    assign dly_tap  = tap_q;
    assign dly_ld   = ld_q;
    assign bitslip  = bs_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign locked   = locked_q;
    assign err      = err_q;
    assign lost     = lost_q;
    assign win_len  = win_q;
    assign slip_cnt = slip_q;

endmodule

// File: tb/tb_adc_lane_align.sv
// Bench for adc_lane_align: lane model with tap pass map and bitslip
// rotation, window-search reference model, per-cycle pulse/lock checks.

module tb_adc_lane_align;

    localparam int          ST  = 16;
    localparam int          CL  = 64;
    localparam logic [7:0]  PAT = 8'hF0;

    logic       clk = 1'b0;
    logic       rst_pro;
    logic       start;
    logic [7:0] data_in;
    logic [4:0] dly_tap;
    logic       dly_ld, bitslip, busy, done, locked, err, lost;
    logic [5:0] win_len;
    logic [2:0] slip_cnt;

    int total = 0;
    int bad   = 0;

    logic [31:0] pass_map    = '0;
    int          rot_base    = 0;
    bit          never_match = 1'b0;
    bit          corrupt     = 1'b0;
    bit          mon_lock    = 1'b0;

    int         lat_tap = 0;
    int         slips   = 0;
    logic [7:0] ctr     = '0;
    logic       exp_locked = 1'b1;
    logic       exp_lost   = 1'b0;
    int         cyc    = 0;
    int         last_p = -1000;
    int         n_ld   = 0;
    int         n_bs   = 0;

    adc_lane_align #(
        .WIDTH(8), .PATTERN(PAT), .TAP_BITS(5), .SETTLE(ST), .CHECK_LEN(CL)
    ) dut (
        .clk(clk), .rst_pro(rst_pro), .start(start), .data_in(data_in),
        .dly_tap(dly_tap), .dly_ld(dly_ld), .bitslip(bitslip), .busy(busy),
        .done(done), .locked(locked), .err(err), .lost(lost),
        .win_len(win_len), .slip_cnt(slip_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rotl(input logic [7:0] x, input int k);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    function automatic logic [31:0] window(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // brute-force longest run of passing taps; strict > keeps lowest start
    task automatic best_win(input logic [31:0] m, output int bs, output int bl);
        bs = 0;
        bl = 0;
        for (int s = 0; s < 32; s++)
            for (int e = s; e < 32 && m[e]; e++)
                if (e - s + 1 > bl) begin
                    bl = e - s + 1;
                    bs = s;
                end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // lane model: good taps show a fixed rotation of PAT, bad taps churn
    always_comb begin
        if (pass_map[lat_tap])
            data_in = rotl(PAT, never_match ? 1 : (rot_base - slips + 8) % 8);
        else
            data_in = ctr;
        if (corrupt) data_in = data_in ^ 8'h01;
    end

    always @(posedge clk or posedge rst_pro) begin
        if (rst_pro) begin
            lat_tap <= 0;
            ctr     <= '0;
        end else begin
            ctr <= ctr + 8'd1;
            if (dly_ld) lat_tap <= int'(dly_tap);
            if (bitslip) slips <= (slips + 1) % 8;
        end
    end

    always @(posedge clk) begin
        if (!mon_lock) begin
            exp_locked <= 1'b1;
            exp_lost   <= 1'b0;
        end else if (data_in != PAT) begin
            exp_locked <= 1'b0;
            exp_lost   <= 1'b1;
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst_pro) begin
            last_p = -1000;
        end else begin
            if (dly_ld) n_ld++;
            if (bitslip) n_bs++;
            if (dly_ld || bitslip) begin
                chk("pulse_overlap", int'(dly_ld && bitslip), 0);
                chk("pulse_gap_ok", int'(cyc - last_p >= ST + 1), 1);
                last_p = cyc;
            end
            if (mon_lock) begin
                chk("mon_locked", locked, exp_locked);
                chk("mon_lost", lost, exp_lost);
            end
        end
    end

    task automatic run(input bit poke);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        mon_lock = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("ld_not_yet", dly_ld, 0);
        chk("lost_clr", lost, 0);
        chk("done_clr", done, 0);
        @(negedge clk);
        chk("ld_first", dly_ld, 1);
        for (int i = 0; i < 20000; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            start = poke && (i == 300 || i == 900);
            @(negedge clk);
        end
        start = 1'b0;
        chk("run_timeout", int'(ok), 1);
    endtask

    task automatic check_model(input int s0, input int ld0, input int bs0);
        int bs, bl, ns;
        best_win(pass_map, bs, bl);
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        if (bl == 0) begin
            chk("err", err, 1);
            chk("locked", locked, 0);
            chk("n_bitslip", n_bs - bs0, 0);
            chk("n_dly_ld", n_ld - ld0, 32);
            chk("tap_hold", dly_tap, 31);
            chk("win_len", win_len, 0);
        end else begin
            ns = never_match ? 7 : (rot_base - s0 + 8) % 8;
            chk("dly_tap", dly_tap, bs + (bl - 1) / 2);
            chk("win_len", win_len, bl);
            chk("n_dly_ld", n_ld - ld0, 33);
            chk("slip_cnt", slip_cnt, ns);
            chk("n_bitslip", n_bs - bs0, ns);
            chk("err", err, int'(never_match));
            chk("locked", locked, int'(!never_match));
        end
    endtask

    initial begin
        int s0, l0, b0;
        bit ok;
        rst_pro = 1'b1;
        start   = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {dly_tap, win_len, slip_cnt, dly_ld, bitslip,
                           busy, done, locked, err, lost}, 0);
        rst_pro = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_after_rst", {busy, done}, 0);

        pass_map = window(10, 20);
        rot_base = 3;
        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b1);
        check_model(s0, l0, b0);
        chk("t1_tap", dly_tap, 15);
        chk("t1_win", win_len, 11);
        chk("t1_slip", slip_cnt, 3);
        chk("t1_ld", n_ld - l0, 33);
        chk("t1_locked", locked, 1);

        mon_lock = 1'b1;
        repeat (5) @(negedge clk);
        corrupt = 1'b1;
        chk("pre_loss_locked", locked, 1);
        @(negedge clk);
        corrupt = 1'b0;
        chk("loss_locked", locked, 0);
        chk("loss_lost", lost, 1);
        repeat (5) @(negedge clk);
        chk("loss_hold", {locked, lost}, 1);

        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b0);
        check_model(s0, l0, b0);
        chk("relock_lost", lost, 0);
        chk("relock_slip", slip_cnt, 0);
        mon_lock = 1'b1;
        repeat (10) @(negedge clk);
        mon_lock = 1'b0;

        pass_map = window(2, 5) | window(20, 23);
        rot_base = 5;
        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b0);
        check_model(s0, l0, b0);
        chk("t2_tap", dly_tap, 3);
        chk("t2_win", win_len, 4);

        pass_map = '0;
        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b0);
        check_model(s0, l0, b0);
        chk("t3_err", err, 1);
        chk("t3_bs", n_bs - b0, 0);

        pass_map    = '1;
        never_match = 1'b1;
        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b0);
        check_model(s0, l0, b0);
        chk("t4_bs", n_bs - b0, 7);
        chk("t4_slip", slip_cnt, 7);
        chk("t4_err", err, 1);
        chk("t4_win", win_len, 32);
        chk("t4_tap", dly_tap, 15);
        never_match = 1'b0;

        pass_map = window(10, 20);
        rot_base = 3;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (lat_tap == 12) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("reach_tap12", int'(ok), 1);
        repeat (ST + 5) @(negedge clk);
        chk("pre_rst_tap", dly_tap, 12);
        chk("pre_rst_busy", busy, 1);
        l0 = n_ld;
        rst_pro = 1'b1;
        #1;
        chk("rst_async_outs", {dly_tap, win_len, slip_cnt, dly_ld, bitslip,
                               busy, done, locked, err, lost}, 0);
        repeat (3) @(negedge clk);
        chk("rst_no_ld", n_ld - l0, 0);
        rst_pro = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_at_release_ignored", busy, 0);
        repeat (3) @(negedge clk);
        chk("still_idle", {busy, dly_ld}, 0);

        s0 = slips; l0 = n_ld; b0 = n_bs;
        run(1'b0);
        check_model(s0, l0, b0);
        chk("final_locked", locked, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
